au_issue_arbiter: RTL and testbench
===================================

Name: au_issue_arbiter

Overview:
- Round-robin scheduler sharing the single address unit between NREQ load/store requesters (load-store reservation-station slots).
- Each cycle it picks at most one ready requester, handshakes it, and drives a registered issue packet (operands, op, ROB tag, store data) into the address unit inputs.
- Honours the pipeline-wide pause and the ROB flush.

Parameters:
- NREQ, 4, number of requesters (2..8); requester i owns bit i / slice i of every flattened bus.
- PTRW, 2, width of the round-robin pointer; must equal clog2(NREQ).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous active-low reset.
- pause  input  1  global stall; freezes the block.
- flush  input  1  synchronous ROB flush (mispredict); kills the issue slot.
- req_valid  input  NREQ  requester i holds a packet.
- req_ready  output  NREQ  one-hot grant; combinational.
- req_value1  input  32*NREQ  base operand per requester.
- req_value2  input  32*NREQ  offset operand per requester.
- req_op  input  5*NREQ  load/store opcode per requester.
- req_rob  input  3*NREQ  ROB tag per requester.
- req_ls_value  input  32*NREQ  store data per requester.
- value1  output  32  registered base to the address unit.
- value2  output  32  registered offset to the address unit.
- op_output  output  5  registered opcode; 5'b11111 = NOP/idle.
- rob_number_output  output  3  registered ROB tag.
- ls_value_output  output  32  registered store data.
- issue_valid  output  1  registered; 1 iff op_output != 5'b11111.
- grant_idx  output  PTRW  registered index of the last granted requester.

Behaviour:
- Reset (rst=0, asynchronous):
  - op_output=5'b11111; rob_number_output=0.
  - value1, value2, ls_value_output = 0.
  - issue_valid=0; grant_idx=0; rr pointer ptr=0.
- Eligibility: requester i is eligible when req_valid[i]=1 and its req_op slice != 5'b11111. A valid requester carrying the NOP op is never granted.
- Selection (combinational):
  - Scan i = ptr, ptr+1, ..., wrapping mod NREQ; the first eligible i wins.
  - req_ready is one-hot on the winner; all zero if there is no winner, or if pause=1, flush=1 or rst=0.
  - Transfer occurs when req_valid[i] & req_ready[i] are high at the posedge. The requester drops or replaces its packet on the following cycle.
- Posedge update, in priority order:
  - flush=1:
    - op_output=5'b11111; rob_number_output=0; issue_valid=0.
    - Data outputs hold; ptr and grant_idx hold; no grant.
    - flush overrides pause.
  - else pause=1: all registers hold, including ptr; no grant.
  - else winner w exists:
    - Outputs load slice w (value1, value2, op, rob, ls_value); issue_valid=1; grant_idx=w.
    - ptr = (w+1) mod NREQ.
  - else (no winner):
    - op_output=5'b11111; rob_number_output=0; issue_valid=0.
    - Data outputs, grant_idx and ptr hold.
- Latency: a request granted at edge k appears on the outputs immediately after edge k. Back-to-back grants are possible every cycle; throughput is 1 packet/cycle.
- Fairness: any continuously eligible requester is granted within NREQ grants.
- Wrap-around: with ptr=NREQ-1 and requester NREQ-1 winning, ptr becomes 0.
- Reset asserted mid-operation clears outputs immediately, without waiting for clk. Deassertion is released on the next posedge, and the first grant can occur on that edge.
- No arithmetic is performed here; the address add stays in the address unit.

Test Plan:
- Reset: hold rst=0 with all req_valid=1 -> req_ready=0000, op_output=5'b11111, issue_valid=0, grant_idx=0. Release rst -> first edge grants requester 0.
- Round robin: all four requesters valid with ops 5'd3, 5'd4, 5'd5, 5'd6 and rob 1..4, held valid -> grants 0,1,2,3,0 on consecutive edges; rob_number_output sequence 1,2,3,4,1.
- Sparse and wrap: only req 3 (value1=32'h100, value2=32'h8) and req 1 valid, ptr=2 -> req 3 granted first: value1=32'h100, value2=32'h8, grant_idx=3, ptr=0. Next edge -> req 1 granted.
- Pause: grant req 2 (ls_value=32'hDEADBEEF), then pause=1 for 3 cycles with others valid -> req_ready=0 throughout; outputs frozen with ls_value_output=32'hDEADBEEF. Release pause -> next grant is req 3.
- Flush priority: pause=1 and flush=1 together while an issue is held -> next edge op_output=5'b11111, issue_valid=0, rob_number_output=0, no req_ready.
- NOP filtering: req 0 valid with op=5'b11111, req 1 valid with op=5'd2 -> req 1 granted, req 0 never receives req_ready.

Source files
------------

// File: rtl/au_issue_arbiter.sv
// Round-robin issue arbiter feeding the single address unit from NREQ load/store slots.
// Grant is combinational; the issue packet to the address unit is registered.
module au_issue_arbiter #(
    parameter int NREQ = 4,
    parameter int PTRW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pause,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_value1,
    input  logic [32*NREQ-1:0]   req_value2,
    input  logic [5*NREQ-1:0]    req_op,
    input  logic [3*NREQ-1:0]    req_rob,
    input  logic [32*NREQ-1:0]   req_ls_value,
    output logic [31:0]          value1,
    output logic [31:0]          value2,
    output logic [4:0]           op_output,
    output logic [2:0]           rob_number_output,
    output logic [31:0]          ls_value_output,
    output logic                 issue_valid,
    output logic [PTRW-1:0]      grant_idx
);

    localparam logic [4:0] OP_NOP = 5'b11111;

    logic [PTRW-1:0] r_ptr;
    logic [PTRW-1:0] r_grant_idx;
    logic [31:0]     r_value1;
    logic [31:0]     r_value2;
    logic [31:0]     r_ls_value;
    logic [4:0]      r_op;
    logic [2:0]      r_rob;
    logic            r_issue_valid;

    logic [NREQ-1:0] w_eligible;
    logic            w_found;
    logic [PTRW-1:0] w_win;
    logic            w_grant_en;
    logic [PTRW-1:0] w_ptr_next;
    logic [31:0]     w_sel_value1;
    logic [31:0]     w_sel_value2;
    logic [31:0]     w_sel_ls_value;
    logic [4:0]      w_sel_op;
    logic [2:0]      w_sel_rob;

    // A slot holding the NOP opcode is treated as empty even when valid.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
            assign w_eligible[gi] = req_valid[gi] && (req_op[5*gi +: 5] != OP_NOP);
            assign req_ready[gi]  = w_grant_en && (w_win == PTRW'(gi));
        end
    endgenerate

    always_comb begin
        int w_idx;
        w_idx   = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx[PTRW-1:0];
            end
        end
    end

    assign w_grant_en = w_found && !pause && !flush && rst;
    assign w_ptr_next = (w_win == PTRW'(NREQ - 1)) ? '0 : w_win + PTRW'(1);

    assign w_sel_value1   = req_value1[32*w_win +: 32];
    assign w_sel_value2   = req_value2[32*w_win +: 32];
    assign w_sel_ls_value = req_ls_value[32*w_win +: 32];
    assign w_sel_op       = req_op[5*w_win +: 5];
    assign w_sel_rob      = req_rob[3*w_win +: 3];

    // Flush beats pause: a killed slot must not survive a concurrent stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr         <= '0;
            r_grant_idx   <= '0;
            r_value1      <= '0;
            r_value2      <= '0;
            r_ls_value    <= '0;
            r_op          <= OP_NOP;
            r_rob         <= '0;
            r_issue_valid <= 1'b0;
        end else if (flush) begin
            r_op          <= OP_NOP;
            r_rob         <= '0;
            r_issue_valid <= 1'b0;
        end else if (pause) begin
            r_ptr         <= r_ptr;
        end else if (w_found) begin
            r_value1      <= w_sel_value1;
            r_value2      <= w_sel_value2;
            r_ls_value    <= w_sel_ls_value;
            r_op          <= w_sel_op;
            r_rob         <= w_sel_rob;
            r_issue_valid <= 1'b1;
            r_grant_idx   <= w_win;
            r_ptr         <= w_ptr_next;
        end else begin
            r_op          <= OP_NOP;
            r_rob         <= '0;
            r_issue_valid <= 1'b0;
        end
    end

    assign value1            = r_value1;
    assign value2            = r_value2;
    assign ls_value_output   = r_ls_value;
    assign op_output         = r_op;
    assign rob_number_output = r_rob;
    assign issue_valid       = r_issue_valid;
    assign grant_idx         = r_grant_idx;

endmodule

// File: tb/tb_au_issue_arbiter.sv
// Directed plus randomized bench for au_issue_arbiter against a distance-based
// round-robin reference model.
module tb_au_issue_arbiter;

    localparam int N = 4;
    localparam logic [4:0] NOP = 5'b11111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, pause, flush;
    logic [N-1:0]      req_valid, req_ready;
    logic [32*N-1:0]   req_value1, req_value2, req_ls_value;
    logic [5*N-1:0]    req_op;
    logic [3*N-1:0]    req_rob;
    logic [31:0]       value1, value2, ls_value_output;
    logic [4:0]        op_output;
    logic [2:0]        rob_number_output;
    logic              issue_valid;
    logic [1:0]        grant_idx;

    logic        t_valid [N];
    logic [31:0] t_v1 [N];
    logic [31:0] t_v2 [N];
    logic [31:0] t_ls [N];
    logic [4:0]  t_op [N];
    logic [2:0]  t_rob [N];

    always_comb begin
        req_valid = '0; req_value1 = '0; req_value2 = '0; req_ls_value = '0;
        req_op = '0; req_rob = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = t_valid[i];
            req_value1[32*i +: 32]  = t_v1[i];
            req_value2[32*i +: 32]  = t_v2[i];
            req_ls_value[32*i +: 32] = t_ls[i];
            req_op[5*i +: 5]        = t_op[i];
            req_rob[3*i +: 3]       = t_rob[i];
        end
    end

    au_issue_arbiter #(.NREQ(N), .PTRW(2)) dut (
        .clk(clk), .rst(rst), .pause(pause), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_value1(req_value1), .req_value2(req_value2), .req_op(req_op),
        .req_rob(req_rob), .req_ls_value(req_ls_value),
        .value1(value1), .value2(value2), .op_output(op_output),
        .rob_number_output(rob_number_output), .ls_value_output(ls_value_output),
        .issue_valid(issue_valid), .grant_idx(grant_idx)
    );

    int          m_ptr, m_gidx;
    logic [31:0] m_v1, m_v2, m_ls;
    logic [4:0]  m_op;
    logic [2:0]  m_rob;
    logic        m_iv;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_gidx = 0; m_v1 = '0; m_v2 = '0; m_ls = '0;
        m_op = NOP; m_rob = '0; m_iv = 1'b0;
    endtask

    // Winner = eligible requester at the smallest circular distance from the pointer.
    function automatic int model_winner();
        int best, bd, d;
        best = -1; bd = N;
        for (int i = 0; i < N; i++) begin
            if (t_valid[i] && t_op[i] != NOP) begin
                d = (i - m_ptr + N) % N;
                if (d < bd) begin bd = d; best = i; end
            end
        end
        return best;
    endfunction

    task automatic check_outs();
        chk("value1", value1, m_v1);
        chk("value2", value2, m_v2);
        chk("ls_value", ls_value_output, m_ls);
        chk("op", 32'(op_output), 32'(m_op));
        chk("rob", 32'(rob_number_output), 32'(m_rob));
        chk("issue_valid", 32'(issue_valid), 32'(m_iv));
        chk("grant_idx", 32'(grant_idx), 32'(m_gidx));
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic cycle();
        int w;
        logic [N-1:0] exp_rdy;
        #1;
        w = model_winner();
        exp_rdy = '0;
        if (w >= 0 && !pause && !flush && rst) exp_rdy[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (flush) begin
            m_op = NOP; m_rob = '0; m_iv = 1'b0;
        end else if (pause) begin
            m_iv = m_iv;
        end else if (w >= 0) begin
            m_v1 = t_v1[w]; m_v2 = t_v2[w]; m_ls = t_ls[w];
            m_op = t_op[w]; m_rob = t_rob[w]; m_iv = 1'b1;
            m_gidx = w; m_ptr = (w + 1) % N;
        end else begin
            m_op = NOP; m_rob = '0; m_iv = 1'b0;
        end
        #1;
        check_outs();
        @(negedge clk);
    endtask

    task automatic set_all_rr();
        for (int i = 0; i < N; i++) begin
            t_valid[i] = 1'b1;
            t_op[i]    = 5'(3 + i);
            t_rob[i]   = 3'(1 + i);
            t_v1[i]    = 32'h1000 + 32'(i);
            t_v2[i]    = 32'h20 + 32'(i);
            t_ls[i]    = 32'hA000_0000 + 32'(i);
        end
    endtask

    task automatic clear_valid();
        for (int i = 0; i < N; i++) t_valid[i] = 1'b0;
    endtask

    initial begin
        logic [2:0] rr_rob [5];
        rr_rob = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        rst = 1'b0; pause = 1'b0; flush = 1'b0;
        set_all_rr();
        model_reset();

        // Reset held with every requester valid
        #12;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_op", 32'(op_output), 32'(NOP));
        chk("rst_iv", 32'(issue_valid), 32'h0);
        chk("rst_gidx", 32'(grant_idx), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Round robin 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_rob", 32'(rob_number_output), 32'(rr_rob[k]));
            chk("rr_gidx", 32'(grant_idx), 32'(k % N));
        end

        // Steer pointer to 2, then sparse requesters 3 and 1
        clear_valid(); t_valid[1] = 1'b1;
        cycle();
        t_valid[3] = 1'b1; t_v1[3] = 32'h100; t_v2[3] = 32'h8;
        cycle();
        chk("sparse_v1", value1, 32'h100);
        chk("sparse_v2", value2, 32'h8);
        chk("sparse_gidx", 32'(grant_idx), 32'd3);
        cycle();
        chk("wrap_gidx", 32'(grant_idx), 32'd1);

        // Pause freezes the packet from requester 2
        clear_valid(); t_valid[2] = 1'b1; t_ls[2] = 32'hDEADBEEF;
        cycle();
        set_all_rr(); t_ls[2] = 32'hDEADBEEF;
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("pause_ls", ls_value_output, 32'hDEADBEEF);
        end
        pause = 1'b0;
        cycle();
        chk("unpause_gidx", 32'(grant_idx), 32'd3);

        // Flush overrides pause
        pause = 1'b1; flush = 1'b1;
        cycle();
        chk("flush_op", 32'(op_output), 32'(NOP));
        chk("flush_iv", 32'(issue_valid), 32'h0);
        pause = 1'b0; flush = 1'b0;

        // NOP opcode is never granted
        clear_valid();
        t_valid[0] = 1'b1; t_op[0] = NOP;
        t_valid[1] = 1'b1; t_op[1] = 5'd2;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("nop_gidx", 32'(grant_idx), 32'd1);
        end

        // Asynchronous reset mid-cycle
        set_all_rr();
        cycle();
        #2 rst = 1'b0;
        #1;
        chk("arst_op", 32'(op_output), 32'(NOP));
        chk("arst_iv", 32'(issue_valid), 32'h0);
        chk("arst_v1", value1, 32'h0);
        chk("arst_ready", 32'(req_ready), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle();
        chk("arst_first_gidx", 32'(grant_idx), 32'd0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                t_valid[i] = ($urandom_range(0, 2) != 0);
                t_op[i]    = ($urandom_range(0, 5) == 0) ? NOP : 5'($urandom_range(0, 30));
                t_rob[i]   = 3'($urandom);
                t_v1[i]    = $urandom;
                t_v2[i]    = $urandom;
                t_ls[i]    = $urandom;
            end
            pause = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
